// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA position/sync generator with a clocks-per-pixel prescaler and frame counter
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_S0   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_S1   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_S0   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_S1   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0]    P_LAST = 2'(PIX_DIV - 1);

    logic          r_run;
    logic [1:0]    r_p;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_line_start;
    logic          r_frame_start;
    logic [7:0]    r_frame_cnt;

    logic          w_tick;
    logic          w_load;
    logic          w_x_end;
    logic          w_y_end;
    logic          w_wrap;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

    // Next position: the first enabled clock after reset loads (0,0) instead of advancing
    always_comb begin
        w_tick  = r_run && (r_p == P_LAST);
        w_load  = !r_run || w_tick;
        w_x_end = r_x == H_LAST;
        w_y_end = r_y == V_LAST;
        w_wrap  = w_tick && w_x_end && w_y_end;
        w_px    = (!r_run || w_x_end) ? '0 : r_x + XW'(1);
        w_py    = !r_run ? '0 : !w_x_end ? r_y : w_y_end ? '0 : r_y + YW'(1);
    end

    // Position, decoded outputs and pulses all register together so they never skew
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_p           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (ena) begin
            r_run <= 1'b1;
            r_p   <= w_load ? '0 : r_p + 2'd1;
            if (w_load) begin
                r_x           <= w_px;
                r_y           <= w_py;
                r_active      <= (w_px < H_VIS) && (w_py < V_VIS);
                r_hsync       <= (w_px >= H_S0 && w_px < H_S1) ? H_POL : ~H_POL;
                r_vsync       <= (w_py >= V_S0 && w_py < V_S1) ? V_POL : ~V_POL;
                r_line_start  <= w_px == '0;
                r_frame_start <= (w_px == '0) && (w_py == '0);
            end else begin
                r_line_start  <= 1'b0;
                r_frame_start <= 1'b0;
            end
            if (w_wrap)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three small-config instances (PIX_DIV 1, PIX_DIV 3, inverted sync polarity)
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_a = 1'b1;
    logic       ena_b = 1'b1;
    logic [3:0] x_a, x_b, x_c;
    logic [2:0] y_a, y_b, y_c;
    logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
    logic       act_a, act_b, act_c, ls_a, ls_b, ls_c, fs_a, fs_b, fs_c;
    logic [7:0] fc_a, fc_b, fc_c;
    int errors = 0;
    int checks = 0;
    int ka = -1;
    int nb = -1;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(1), .XW(4), .YW(3)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
        .active(act_a), .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(3), .XW(4), .YW(3)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
        .active(act_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b));

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .XW(4), .YW(3)) u_c (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .x(x_c), .y(y_c), .hsync(hs_c), .vsync(vs_c),
        .active(act_c), .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ka=%0d nb=%0d: observed %0d expected %0d", tag, ka, nb, obs, exp);
        end
    endtask

    // ka/nb count enabled edges since reset release; the release edge itself is index 0
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            ka = ka + (ena_a ? 1 : 0);
            nb = nb + (ena_b ? 1 : 0);
        end else begin
            ka = -1;
            nb = -1;
        end
        #1;
    endtask

    // Line = 14 pixels, frame = 7 lines; B holds each pixel 3 enabled clocks
    task automatic check_all();
        int n, xe, ye;
        xe = ka % 14;
        ye = (ka / 14) % 7;
        chk("a_x", 32'(x_a), xe);
        chk("a_y", 32'(y_a), ye);
        chk("a_act", 32'(act_a), (xe < 8 && ye < 4) ? 1 : 0);
        chk("a_hs", 32'(hs_a), (xe >= 10 && xe < 12) ? 0 : 1);
        chk("a_vs", 32'(vs_a), (ye == 5) ? 0 : 1);
        chk("a_ls", 32'(ls_a), (xe == 0) ? 1 : 0);
        chk("a_fs", 32'(fs_a), (ka % 98 == 0) ? 1 : 0);
        chk("a_fc", 32'(fc_a), (ka / 98) % 256);
        chk("c_hs", 32'(hs_c), (xe >= 10 && xe < 12) ? 1 : 0);
        chk("c_vs", 32'(vs_c), (ye == 5) ? 1 : 0);
        n  = nb / 3;
        xe = n % 14;
        ye = (n / 14) % 7;
        chk("b_x", 32'(x_b), xe);
        chk("b_y", 32'(y_b), ye);
        chk("b_act", 32'(act_b), (xe < 8 && ye < 4) ? 1 : 0);
        chk("b_hs", 32'(hs_b), (xe >= 10 && xe < 12) ? 0 : 1);
        chk("b_ls", 32'(ls_b), (nb % 3 == 0 && xe == 0) ? 1 : 0);
        chk("b_fs", 32'(fs_b), (nb % 294 == 0) ? 1 : 0);
        chk("b_fc", 32'(fc_b), (n / 98) % 256);
    endtask

    task automatic run_a(input int target);
        while (ka < target) begin
            step();
            check_all();
        end
    endtask

    task automatic run_b(input int target);
        while (nb < target) begin
            step();
            check_all();
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_a_x", 32'(x_a), 0);
        chk("rst_a_y", 32'(y_a), 0);
        chk("rst_a_act", 32'(act_a), 0);
        chk("rst_a_hs", 32'(hs_a), 1);
        chk("rst_a_vs", 32'(vs_a), 1);
        chk("rst_a_ls", 32'(ls_a), 0);
        chk("rst_a_fs", 32'(fs_a), 0);
        chk("rst_a_fc", 32'(fc_a), 0);
        chk("rst_c_hs", 32'(hs_c), 0);
        chk("rst_c_vs", 32'(vs_c), 0);
        rst_n = 1'b1;
        step();
        check_all();
        chk("e0_a_act", 32'(act_a), 1);
        chk("e0_a_ls", 32'(ls_a), 1);
        chk("e0_a_fs", 32'(fs_a), 1);
        chk("e0_b_fs", 32'(fs_b), 1);
        step();
        check_all();
        chk("e1_a_x", 32'(x_a), 1);
        chk("e1_b_x", 32'(x_b), 0);
        chk("e1_b_ls_once", 32'(ls_b), 0);
        run_b(210);
        chk("b_ls_line5", 32'(ls_b), 1);
        ena_b = 1'b0;
        repeat (3) begin
            step();
            check_all();
            chk("b_ls_hold", 32'(ls_b), 1);
        end
        ena_b = 1'b1;
        step();
        check_all();
        chk("b_ls_clear", 32'(ls_b), 0);
        run_b(229);
        chk("b_x_mid", 32'(x_b), 6);
        ena_b = 1'b0;
        repeat (5) begin
            step();
            check_all();
            chk("b_x_frozen", 32'(x_b), 6);
        end
        ena_b = 1'b1;
        step();
        chk("b_x_resume6", 32'(x_b), 6);
        step();
        chk("b_x_resume7", 32'(x_b), 7);
        run_b(293);
        chk("b_fs_early", 32'(fs_b), 0);
        step();
        check_all();
        chk("b_fs_frame", 32'(fs_b), 1);
        chk("b_fc_frame", 32'(fc_b), 1);
        run_a(327);
        chk("pre_rst_x", 32'(x_a), 5);
        chk("pre_rst_y", 32'(y_a), 2);
        chk("pre_rst_fc", 32'(fc_a), 3);
        rst_n = 1'b0;
        step();
        chk("mid_rst_x", 32'(x_a), 0);
        chk("mid_rst_y", 32'(y_a), 0);
        chk("mid_rst_fc", 32'(fc_a), 0);
        chk("mid_rst_act", 32'(act_a), 0);
        chk("mid_rst_hs", 32'(hs_a), 1);
        chk("mid_rst_vs", 32'(vs_a), 1);
        chk("mid_rst_ls", 32'(ls_a), 0);
        chk("mid_rst_b_fc", 32'(fc_b), 0);
        chk("mid_rst_c_hs", 32'(hs_c), 0);
        rst_n = 1'b1;
        step();
        check_all();
        chk("rel_fs", 32'(fs_a), 1);
        chk("rel_fc", 32'(fc_a), 0);
        run_a(256 * 98 - 1);
        chk("wrap_pre_fc", 32'(fc_a), 255);
        step();
        check_all();
        chk("wrap_fc", 32'(fc_a), 0);
        chk("wrap_fs", 32'(fs_a), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
